multi_tile_result_fifo: RTL and testbench

- Bank of NUM_TILES independent result FIFOs, one per compute tile, with an integrated round-robin drain arbiter.
- Presents a single tagged valid/ready result stream (data plus source tile index) to the result writeback path.
- Successor to the single-tile result FIFO. Adds:
  - channel count
  - sticky overflow flags
  - registered output with backpressure
  - burst-lock drain mode

---
 rtl/multi_tile_result_fifo_pkg.sv | 11 +
 rtl/multi_tile_result_fifo_rr_arbiter.sv | 52 +++++
 rtl/multi_tile_result_fifo.sv | 156 +++++++++++++++
 tb/tb_multi_tile_result_fifo.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/multi_tile_result_fifo_pkg.sv
// rtl/multi_tile_result_fifo_pkg.sv - shared types and defaults for the multi-tile result FIFO
package multi_tile_result_fifo_pkg;

    localparam int NUM_TILES_DEFAULT    = 4;
    localparam int DEPTH_DEFAULT        = 128;
    localparam int RESULT_WIDTH_DEFAULT = 16;

    typedef logic [$clog2(NUM_TILES_DEFAULT)-1:0] tile_idx_t;
    typedef logic [$clog2(DEPTH_DEFAULT):0]       cnt_t;

endpackage

// File: rtl/multi_tile_result_fifo_rr_arbiter.sv
// rtl/multi_tile_result_fifo_rr_arbiter.sv - round-robin arbiter with optional hold on the last grant
module rr_arbiter
    import multi_tile_result_fifo_pkg::*;
#(
    parameter int N = NUM_TILES_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N-1:0]         i_req,
    input  logic                 i_advance,
    input  logic                 i_lock,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_gnt_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] rr_q, rr_d, prev;
    logic          found;

    always_comb begin
        // rr_q always sits one past the last grant, so prev is the tile granted last
        prev      = (rr_q == '0) ? IW'(N - 1) : rr_q - IW'(1);
        o_gnt_idx = '0;
        found     = 1'b0;
        if (i_lock && i_req[prev]) begin
            o_gnt_idx = prev;
            found     = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!found && i_req[(int'(rr_q) + i) % N]) begin
                    o_gnt_idx = IW'((int'(rr_q) + i) % N);
                    found     = 1'b1;
                end
            end
        end
        o_gnt = found ? (N'(1) << o_gnt_idx) : '0;
        rr_d  = rr_q;
        if (i_advance && found) begin
            rr_d = (o_gnt_idx == IW'(N - 1)) ? '0 : o_gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/multi_tile_result_fifo.sv
// rtl/multi_tile_result_fifo.sv - per-tile result FIFOs drained through one registered tagged stream
// Optional burst-lock drain mode: MULTI_TILE_RESULT_FIFO_BURST_LOCK_EN
module multi_tile_result_fifo
    import multi_tile_result_fifo_pkg::*;
#(
    parameter int NUM_TILES    = NUM_TILES_DEFAULT,
    parameter int DEPTH        = DEPTH_DEFAULT,
    parameter int DATA_WIDTH   = RESULT_WIDTH_DEFAULT,
    parameter int AFULL_MARGIN = 8,
    parameter int BURST_LEN    = 16
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset,
    input  logic [NUM_TILES*DATA_WIDTH-1:0]          i_wr_data,
    input  logic [NUM_TILES-1:0]                     i_wr_en,
    output logic [NUM_TILES-1:0]                     o_full,
    output logic [NUM_TILES-1:0]                     o_afull,
    output logic [NUM_TILES*($clog2(DEPTH)+1)-1:0]   o_count,
    output logic [NUM_TILES-1:0]                     o_overflow,
    input  logic [NUM_TILES-1:0]                     i_overflow_clr,
    output logic [DATA_WIDTH-1:0]                    o_rd_data,
    output logic [$clog2(NUM_TILES)-1:0]             o_rd_tile,
    output logic                                     o_rd_valid,
    input  logic                                     i_rd_ready,
    output logic                                     o_all_empty
);

    localparam int IW = $clog2(NUM_TILES);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [NUM_TILES-1:0]  req, gnt;
    logic [IW-1:0]         gnt_idx;
    logic                  load, lock;
    logic [DATA_WIDTH-1:0] head [NUM_TILES];

    for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]         count_q, count_d;
        logic                  ovf_q, ovf_d, full, push, pop;

        always_comb begin
            full     = (count_q == CW'(DEPTH));
            push     = i_wr_en[t] && !full;
            pop      = load && gnt[t];
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            count_d  = count_q + CW'(push) - CW'(pop);
            ovf_d    = ovf_q;
            if (i_overflow_clr[t]) ovf_d = 1'b0;
            if (i_wr_en[t] && full) ovf_d = 1'b1;
        end

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                ovf_q    <= ovf_d;
            end
        end

        always_ff @(posedge i_clk) begin
            if (push) mem_q[wr_ptr_q] <= i_wr_data[t*DATA_WIDTH +: DATA_WIDTH];
        end

        assign req[t]                = (count_q != '0);
        assign head[t]               = mem_q[rd_ptr_q];
        assign o_full[t]             = full;
        assign o_afull[t]            = (count_q >= CW'(DEPTH - AFULL_MARGIN));
        assign o_count[t*CW +: CW]   = count_q;
        assign o_overflow[t]         = ovf_q;
    end

`ifdef MULTI_TILE_RESULT_FIFO_BURST_LOCK_EN
    localparam int BW = $clog2(BURST_LEN + 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [IW-1:0] last_q, last_d;

    always_comb begin
        lock   = (bcnt_q != '0) && (bcnt_q < BW'(BURST_LEN));
        bcnt_d = bcnt_q;
        last_d = last_q;
        if (load) begin
            bcnt_d = (lock && gnt_idx == last_q) ? bcnt_q + BW'(1) : BW'(1);
            last_d = gnt_idx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bcnt_q <= '0;
            last_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            last_q <= last_d;
        end
    end
`else
    // BURST_LEN only matters when burst lock is built in
    assign lock = 1'b0 & (BURST_LEN > 0);
`endif

    rr_arbiter #(.N(NUM_TILES)) u_arb (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_req     (req),
        .i_advance (load),
        .i_lock    (lock),
        .o_gnt     (gnt),
        .o_gnt_idx (gnt_idx)
    );

    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [IW-1:0]         rd_tile_q, rd_tile_d;

    always_comb begin
        load       = (!rd_valid_q || i_rd_ready) && (|req);
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_tile_d  = rd_tile_q;
        if (load) begin
            rd_valid_d = 1'b1;
            rd_data_d  = head[gnt_idx];
            rd_tile_d  = gnt_idx;
        end else if (i_rd_ready) begin
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_tile_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_tile_q  <= rd_tile_d;
        end
    end

    assign o_rd_valid  = rd_valid_q;
    assign o_rd_data   = rd_data_q;
    assign o_rd_tile   = rd_tile_q;
    assign o_all_empty = !(|req) && !rd_valid_q;

endmodule

// File: tb/tb_multi_tile_result_fifo.sv
// tb/tb_multi_tile_result_fifo.sv - self-checking bench for multi_tile_result_fifo
module tb_multi_tile_result_fifo;

    localparam int NT    = 4;
    localparam int DEPTH = 128;
    localparam int DW    = 16;
    localparam int AM    = 8;
    localparam int BL    = 2;
    localparam int CW    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NT*DW-1:0] wr_data;
    logic [NT-1:0]    wr_en, clr;
    logic [NT-1:0]    o_full, o_afull, o_overflow;
    logic [NT*CW-1:0] o_count;
    logic [DW-1:0]    o_rd_data;
    logic [1:0]       o_rd_tile;
    logic             o_rd_valid, rd_ready, o_all_empty;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multi_tile_result_fifo #(
        .NUM_TILES(NT), .DEPTH(DEPTH), .DATA_WIDTH(DW), .AFULL_MARGIN(AM), .BURST_LEN(BL)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_wr_data(wr_data), .i_wr_en(wr_en),
        .o_full(o_full), .o_afull(o_afull), .o_count(o_count), .o_overflow(o_overflow),
        .i_overflow_clr(clr), .o_rd_data(o_rd_data), .o_rd_tile(o_rd_tile),
        .o_rd_valid(o_rd_valid), .i_rd_ready(rd_ready), .o_all_empty(o_all_empty)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: one queue per tile, an output slot and a round-robin start index
    logic [DW-1:0] mq [NT][$];
    bit            m_valid = 0;
    logic [DW-1:0] m_data = '0;
    int            m_tile = 0, m_rr = 0, m_last = 0, m_bcnt = 0;
    bit [NT-1:0]   m_ovf = '0;
    bit            started = 0;

    always @(posedge clk) begin : model
        int g;
        bit any;
        bit [NT-1:0] wasfull;
        started = 1;
        if (rst) begin
            for (int t = 0; t < NT; t++) mq[t].delete();
            m_valid = 0; m_data = '0; m_tile = 0; m_rr = 0; m_ovf = '0; m_last = 0; m_bcnt = 0;
        end else begin
            any = 0;
            for (int t = 0; t < NT; t++) begin
                wasfull[t] = (mq[t].size() == DEPTH);
                if (mq[t].size() > 0) any = 1;
            end
            if ((!m_valid || rd_ready) && any) begin
                g = -1;
`ifdef MULTI_TILE_RESULT_FIFO_BURST_LOCK_EN
                if (m_bcnt > 0 && m_bcnt < BL && mq[m_last].size() > 0) g = m_last;
`endif
                for (int k = 0; k < NT; k++)
                    if (g < 0 && mq[(m_rr + k) % NT].size() > 0) g = (m_rr + k) % NT;
`ifdef MULTI_TILE_RESULT_FIFO_BURST_LOCK_EN
                m_bcnt = (g == m_last && m_bcnt > 0 && m_bcnt < BL) ? m_bcnt + 1 : 1;
                m_last = g;
`endif
                m_data  = mq[g].pop_front();
                m_tile  = g;
                m_valid = 1;
                m_rr    = (g + 1) % NT;
            end else if (rd_ready) begin
                m_valid = 0;
            end
            for (int t = 0; t < NT; t++) begin
                if (clr[t]) m_ovf[t] = 0;
                if (wr_en[t]) begin
                    if (wasfull[t]) m_ovf[t] = 1;
                    else mq[t].push_back(wr_data[t*DW +: DW]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            int total;
            total = 0;
            chk("rd_valid", {31'b0, o_rd_valid}, {31'b0, m_valid});
            if (m_valid) begin
                chk("rd_data", {16'b0, o_rd_data}, {16'b0, m_data});
                chk("rd_tile", {30'b0, o_rd_tile}, m_tile);
            end
            for (int t = 0; t < NT; t++) begin
                total += mq[t].size();
                chk("count", {24'b0, o_count[t*CW +: CW]}, mq[t].size());
                chk("full", {31'b0, o_full[t]}, {31'b0, mq[t].size() == DEPTH});
                chk("afull", {31'b0, o_afull[t]}, {31'b0, mq[t].size() >= DEPTH - AM});
                chk("overflow", {31'b0, o_overflow[t]}, {31'b0, m_ovf[t]});
            end
            chk("all_empty", {31'b0, o_all_empty}, {31'b0, (total == 0) && !m_valid});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int order[$];
    int exp_order[8];

    initial begin
        rst = 1; wr_en = '0; wr_data = '0; clr = '0; rd_ready = 0;
        tick(); tick();
        rst = 0;
        tick(); tick();
        chk("reset_all_empty", {31'b0, o_all_empty}, 1);
        chk("reset_valid", {31'b0, o_rd_valid}, 0);
        chk("reset_counts", o_count, 0);
        chk("reset_overflow", {28'b0, o_overflow}, 0);

        // single entry latency
        rd_ready = 1;
        wr_data[2*DW +: DW] = 16'h3C00;
        wr_en = 4'b0100;
        tick();
        wr_en = '0;
        tick();
        chk("lat_valid", {31'b0, o_rd_valid}, 1);
        chk("lat_data", {16'b0, o_rd_data}, 32'h3C00);
        chk("lat_tile", {30'b0, o_rd_tile}, 2);
        tick();
        chk("lat_valid_drop", {31'b0, o_rd_valid}, 0);

        // drain order, two entries per tile
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 2) begin
                wr_en = 4'hF;
                for (int t = 0; t < NT; t++) wr_data[t*DW +: DW] = DW'(16'h0A00 + t * 16 + c);
            end else begin
                wr_en = '0;
            end
            tick();
            if (o_rd_valid) order.push_back(int'(o_rd_tile));
        end
`ifdef MULTI_TILE_RESULT_FIFO_BURST_LOCK_EN
        exp_order = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        chk("order_len", order.size(), 8);
        for (int i = 0; i < 8 && i < order.size(); i++) chk("order_tile", order[i], exp_order[i]);

        // backpressure hold while tile 1 fills
        rd_ready = 0;
        wr_data[0 +: DW] = 16'h00AA;
        wr_en = 4'b0001;
        tick();
        wr_en = '0;
        tick();
        chk("hold_data0", {16'b0, o_rd_data}, 32'hAA);
        chk("hold_tile0", {30'b0, o_rd_tile}, 0);
        for (int i = 1; i <= 128; i++) begin
            wr_en = (i <= 5) ? 4'b1110 : 4'b0010;
            wr_data[1*DW +: DW] = DW'(16'h1000 + i);
            wr_data[2*DW +: DW] = DW'(16'h2000 + i);
            wr_data[3*DW +: DW] = DW'(16'h3000 + i);
            tick();
            if (i <= 5) begin
                chk("hold_data", {16'b0, o_rd_data}, 32'hAA);
                chk("hold_tile", {30'b0, o_rd_tile}, 0);
            end
            if (i == 119) chk("afull_119", {31'b0, o_afull[1]}, 0);
            if (i == 120) chk("afull_120", {31'b0, o_afull[1]}, 1);
        end
        wr_en = '0;
        chk("full_1", {31'b0, o_full[1]}, 1);
        chk("count_128", {24'b0, o_count[1*CW +: CW]}, 128);
        wr_data[1*DW +: DW] = 16'hDEAD;
        wr_en = 4'b0010;
        tick();
        chk("ovf_set", {31'b0, o_overflow[1]}, 1);
        chk("ovf_count", {24'b0, o_count[1*CW +: CW]}, 128);
        clr = 4'b0010;
        tick();
        chk("ovf_set_wins", {31'b0, o_overflow[1]}, 1);
        wr_en = '0;
        tick();
        clr = '0;
        chk("ovf_clr", {31'b0, o_overflow[1]}, 0);

        rd_ready = 1;
        for (int c = 0; c < 400 && !o_all_empty; c++) tick();
        chk("drain_done", {31'b0, o_all_empty}, 1);

        // reset mid-drain
        for (int c = 0; c < 3; c++) begin
            wr_en = 4'b0111;
            for (int t = 0; t < NT; t++) wr_data[t*DW +: DW] = DW'(16'h4000 + t * 16 + c);
            tick();
        end
        wr_en = '0;
        tick();
        rst = 1; tick(); rst = 0;
        chk("mid_reset_counts", o_count, 0);
        chk("mid_reset_valid", {31'b0, o_rd_valid}, 0);
        chk("mid_reset_empty", {31'b0, o_all_empty}, 1);
        wr_data[1*DW +: DW] = 16'h5101;
        wr_data[3*DW +: DW] = 16'h5303;
        wr_en = 4'b1010;
        tick();
        wr_en = '0;
        tick();
        chk("post_reset_tile_a", {30'b0, o_rd_tile}, 1);
        chk("post_reset_data_a", {16'b0, o_rd_data}, 32'h5101);
        tick();
        chk("post_reset_tile_b", {30'b0, o_rd_tile}, 3);
        chk("post_reset_data_b", {16'b0, o_rd_data}, 32'h5303);
        tick();
        chk("post_reset_idle", {31'b0, o_rd_valid}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
